// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS requests into machine words, buffers them in a FIFO and emits them with byte addresses.
// Optional macro ENC_STRICT_EN rejects legal kinds whose unused register/shift fields are nonzero.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
`ifdef ENC_STRICT_EN
  output logic        strict_viol,
`endif
  output logic        done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {RUN, DRAIN, FIN} state_e;
  state_e         state_q, state_d;
  logic [31:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic [31:0]    addr_q, word;
  logic [3:0]     used;
  logic           err_q, ok, acc, push, pop, viol;
  // used = {rs, rt, rd, shamt} register fields the kind actually encodes
  always_comb begin
    word = '0;
    used = '0;
    case (in_kind)
      4'd0:  begin word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20}; used = 4'b1110; end
      4'd1:  begin word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22}; used = 4'b1110; end
      4'd2:  begin word = {6'h0d, in_rs, in_rt, in_imm}; used = 4'b1100; end
      4'd3:  begin word = {6'h23, in_rs, in_rt, in_imm}; used = 4'b1100; end
      4'd4:  begin word = {6'h2b, in_rs, in_rt, in_imm}; used = 4'b1100; end
      4'd5:  begin word = {6'h04, in_rs, in_rt, in_imm}; used = 4'b1100; end
      4'd6:  begin word = {6'h0f, 5'd0, in_rt, in_imm}; used = 4'b0100; end
      4'd7:  begin word = {6'h03, in_target}; used = 4'b0000; end
      4'd8:  begin word = {6'h00, in_rs, 15'd0, 6'h08}; used = 4'b1000; end
      4'd9:  begin word = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00}; used = 4'b0111; end
      4'd10: begin word = {6'h21, in_rs, in_rt, in_imm}; used = 4'b1100; end
      4'd11: begin word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2a}; used = 4'b1110; end
      4'd12: begin word = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h07}; used = 4'b1110; end
      default: begin word = '0; used = 4'b0000; end
    endcase
  end
  assign viol = |{used[3] ? 5'd0 : in_rs, used[2] ? 5'd0 : in_rt,
                  used[1] ? 5'd0 : in_rd, used[0] ? 5'd0 : in_shamt};
`ifdef ENC_STRICT_EN
  logic strict_q;
  assign ok = (in_kind < 4'd14) && !viol;
  assign strict_viol = strict_q;
  always_ff @(posedge clk)
    strict_q <= !reset && acc && (in_kind < 4'd14) && viol;
`else
  logic unused_viol;
  assign unused_viol = viol;
  assign ok = in_kind < 4'd14;
`endif
  assign in_ready  = (state_q == RUN) && (cnt_q != FULL);
  assign acc       = in_valid && in_ready;
  assign push      = acc && ok;
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem_q[rd_q] : '0;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign done      = state_q == FIN;
  always_comb
    state_d = (state_q == RUN && acc && in_last) ? DRAIN :
              (state_q == DRAIN && cnt_q == '0) ? FIN : state_q;
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= word;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      addr_q  <= pop ? addr_q + 32'd4 : addr_q;
      err_q   <= err_q | (acc && !ok);
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: vector table, scripted corner cases and randomized traffic against a scoreboard model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  logic        clk = 0, reset = 1, in_valid = 0, in_ready, in_last = 0;
  logic [3:0]  in_kind = 0;
  logic [4:0]  in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_target = 0;
  logic        out_valid, out_ready = 0, err, done;
  logic [31:0] out_instr, out_addr;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_pops = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference encoder: opcode/funct tables and a field-use mask {target, imm, shamt, rd, rt, rs}
  int op_t [14] = '{0, 0, 13, 35, 43, 4, 15, 3, 0, 0, 33, 0, 0, 0};
  int fn_t [14] = '{32, 34, 0, 0, 0, 0, 0, 0, 8, 0, 0, 42, 7, 0};
  int use_t[14] = '{7, 7, 19, 19, 19, 19, 18, 32, 1, 14, 19, 7, 7, 0};

  function automatic logic [31:0] enc(int k, int rs, int rt, int rd, int sh, int imm, int tg);
    longint w;
    w = longint'(op_t[k]) * 64'd67108864 + longint'(fn_t[k]);
    if (use_t[k] & 1)  w += longint'(rs) * 2097152;
    if (use_t[k] & 2)  w += longint'(rt) * 65536;
    if (use_t[k] & 4)  w += longint'(rd) * 2048;
    if (use_t[k] & 8)  w += longint'(sh) * 64;
    if (use_t[k] & 16) w += longint'(imm);
    if (use_t[k] & 32) w += longint'(tg);
    return w[31:0];
  endfunction

  logic [31:0] q[$];
  logic [31:0] maddr;
  int          mst;
  bit          merr;

  task automatic mreset();
    q.delete();
    maddr = 32'h3000;
    mst   = 0;
    merr  = 0;
  endtask

  // one clock of the model: check outputs now, then advance with the current inputs
  task automatic step(output bit acc);
    bit er, ov;
    int n0, nst;
    n0 = q.size();
    er = (mst == 0) && (n0 < DEPTH);
    ov = n0 > 0;
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ov});
    chk("done", {31'd0, done}, {31'd0, mst == 2});
    chk("err", {31'd0, err}, {31'd0, merr});
    if (ov) begin
      chk("out_instr", out_instr, q[0]);
      chk("out_addr", out_addr, maddr);
    end
    acc = in_valid && er;
    nst = mst;
    if (ov && out_ready) begin
      void'(q.pop_front());
      maddr += 4;
      n_pops++;
    end
    if (acc) begin
      if (in_kind < 14) q.push_back(enc(in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target));
      else merr = 1;
      if (in_last) nst = 1;
    end
    if (mst == 1 && n0 == 0) nst = 2;
    mst = nst;
    tick();
  endtask

  task automatic push_until(input int k, input int rs, input int rt, input int rd, input int sh,
                            input int imm, input int tg, input bit last);
    bit a;
    in_kind = 4'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
    in_imm = 16'(imm); in_target = 26'(tg); in_last = last; in_valid = 1;
    a = 0;
    for (int i = 0; i < 20 && !a; i++) step(a);
    if (!a) begin
      n_chk++; n_fail++;
      $display("FAIL push_timeout: got no accept expected accept of kind %0d", k);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; in_last = 0;
    tick();
    reset = 0;
    mreset();
  endtask

  typedef struct {
    logic [3:0] k; logic [4:0] rs, rt, rd, sh; logic [15:0] imm; logic [25:0] tg; logic [31:0] exp;
  } vec_t;
  vec_t tbl[14];

  initial begin
    bit a;
    logic [31:0] ea;
    tbl[0]  = '{4'd2,  5'd0,  5'd8,  5'd0, 5'd0, 16'h1234, 26'd0, 32'h3408_1234};
    tbl[1]  = '{4'd0,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0000, 26'd0, 32'h0022_1820};
    tbl[2]  = '{4'd3,  5'd29, 5'd5,  5'd0, 5'd0, 16'h0008, 26'd0, 32'h8FA5_0008};
    tbl[3]  = '{4'd7,  5'd0,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h0000C00, 32'h0C00_0C00};
    tbl[4]  = '{4'd9,  5'd7,  5'd3,  5'd2, 5'd4, 16'h0000, 26'd0, 32'h0003_1100};
    tbl[5]  = '{4'd12, 5'd6,  5'd5,  5'd4, 5'd0, 16'h0000, 26'd0, 32'h00C5_2007};
    tbl[6]  = '{4'd5,  5'd1,  5'd2,  5'd0, 5'd0, 16'hFFFF, 26'd0, 32'h1022_FFFF};
    tbl[7]  = '{4'd8,  5'd31, 5'd3,  5'd0, 5'd0, 16'h0000, 26'd0, 32'h03E0_0008};
    tbl[8]  = '{4'd6,  5'd5,  5'd1,  5'd0, 5'd0, 16'hABCD, 26'd0, 32'h3C01_ABCD};
    tbl[9]  = '{4'd1,  5'd1,  5'd2,  5'd3, 5'd9, 16'h0000, 26'd0, 32'h0022_1822};
    tbl[10] = '{4'd4,  5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 26'd0, 32'hAFBF_0010};
    tbl[11] = '{4'd11, 5'd4,  5'd5,  5'd6, 5'd0, 16'h0000, 26'd0, 32'h0085_302A};
    tbl[12] = '{4'd10, 5'd1,  5'd2,  5'd0, 5'd0, 16'h0004, 26'd0, 32'h8422_0004};
    tbl[13] = '{4'd13, 5'd3,  5'd0,  5'd0, 5'd0, 16'h0000, 26'd0, 32'h0000_0000};

    tick();
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_addr", out_addr, 32'h3000);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    ea = 32'h3000;
    out_ready = 1;
    for (int i = 0; i < 14; i++) begin
      in_kind = tbl[i].k; in_rs = tbl[i].rs; in_rt = tbl[i].rt; in_rd = tbl[i].rd;
      in_shamt = tbl[i].sh; in_imm = tbl[i].imm;
      in_target = (tbl[i].k == 4'd7) ? tbl[i].tg : 26'($urandom);
      in_valid = 1;
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 0;
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_out_instr", i), out_instr, tbl[i].exp);
      chk($sformatf("vec%0d_out_addr", i), out_addr, ea);
      tick();
      ea += 4;
    end

    do_reset();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        in_valid = 1; in_kind = 4'd2;
        for (int j = 0; j < 3; j++) step(a);
        out_ready = 1;
      end
      push_until(2, i, i + 8, 0, 0, 16'h100 + i, 0, 0);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) step(a);
    chk("fill_drain_pops", 32'(n_pops), 32'd5);

    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_kind = 4'($urandom_range(0, 15));
      in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom); in_shamt = 5'($urandom);
      in_imm = 16'($urandom); in_target = 26'($urandom);
      step(a);
    end
    in_valid = 0;

    out_ready = 0;
    push_until(15, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) push_until(0, i, 2, 3, 0, 0, 0, 0);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_addr", out_addr, 32'h3000);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

    out_ready = 1;
    n_pops = 0;
    push_until(15, 1, 2, 3, 0, 0, 0, 0);
    push_until(13, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(a);
    chk("last_pops", 32'(n_pops), 32'd1);
    chk("last_done", {31'd0, done}, 32'd1);
    chk("last_in_ready", {31'd0, in_ready}, 32'd0);
    chk("last_err", {31'd0, err}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
